ps2_receiver: RTL and testbench

- Receives serial frames from a PS/2 keyboard on `ps2_clk`/`ps2_dat` and returns them as bytes.
- Decodes scan-code set 2 prefix bytes (0xE0 extended, 0xF0 break) into key events.
- Sits inside the FPGA design (`top`), facing the keyboard model or a real keyboard. It drives the HEX/LEDR logic with raw bytes and decoded make/break events.
- Receive-only: it never drives the PS/2 lines (host-to-device inhibit/commands are out of scope).

---
 rtl/ps2_receiver_pkg.sv | 9 +
 rtl/ps2_receiver_sync.sv | 23 ++
 rtl/ps2_receiver.sv | 138 +++++++++++++
 tb/tb_ps2_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_receiver_pkg.sv
// ps2_receiver_pkg: shared PS/2 FSM state encodings and scan-code set 2 prefix bytes
package ps2_receiver_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;
  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
endpackage

// File: rtl/ps2_receiver_sync.sv
// ps2_sync: 2-FF synchronizers for ps2_clk/ps2_dat plus falling-edge detect (clk, rst in; ps2_clk, ps2_dat async in; fall, dat_s out)
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic dat_s
);
  logic [2:0] c_q;
  logic [1:0] d_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '1;
      d_q <= '1;
    end else begin
      c_q <= {c_q[1:0], ps2_clk};
      d_q <= {d_q[0], ps2_dat};
    end
  end
  assign fall  = c_q[2] & ~c_q[1];
  assign dat_s = d_q[1];
endmodule

// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 frame receiver with watchdog and set-2 make/break decoder (CLOCK_50, reset, ps2_clk, ps2_dat in; scan_code/valid, key_code/extended/released/valid, frame_err out)
module ps2_receiver
  import ps2_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_valid,
  output logic       frame_err
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] TO = WW'(TIMEOUT_CYCLES);
  logic fall, dat_s, good;
  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, scan_code_q, scan_code_d, key_code_q, key_code_d;
  logic par_q, par_d, ext_q, ext_d, brk_q, brk_d;
  logic scan_valid_q, scan_valid_d, key_valid_q, key_valid_d, frame_err_q, frame_err_d;
  logic key_extended_q, key_extended_d, key_released_q, key_released_d;
  logic [WW-1:0] wd_q, wd_d;
  ps2_sync u_sync (
    .clk    (CLOCK_50),
    .rst    (reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .fall   (fall),
    .dat_s  (dat_s)
  );
  assign good = dat_s & (^{sh_q, par_q});
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sh_d           = sh_q;
    par_d          = par_q;
    ext_d          = ext_q;
    brk_d          = brk_q;
    scan_code_d    = scan_code_q;
    key_code_d     = key_code_q;
    key_extended_d = key_extended_q;
    key_released_d = key_released_q;
    scan_valid_d   = 1'b0;
    key_valid_d    = 1'b0;
    frame_err_d    = 1'b0;
    wd_d           = (fall || state_q == S_IDLE) ? '0 : wd_q + 1'b1;
    if (fall) begin
      case (state_q)
        S_IDLE: if (!dat_s) begin
          state_d = S_DATA;
          cnt_d   = '0;
          sh_d    = '0;
        end
        S_DATA: begin
          sh_d    = {dat_s, sh_q[7:1]};
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == 3'd7) ? S_PARITY : S_DATA;
        end
        S_PARITY: begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (good) begin
            scan_code_d  = sh_q;
            scan_valid_d = 1'b1;
            if (sh_q == PS2_EXT) ext_d = 1'b1;
            else if (sh_q == PS2_BRK) brk_d = 1'b1;
            else begin
              key_code_d     = sh_q;
              key_extended_d = ext_q;
              key_released_d = brk_q;
              key_valid_d    = 1'b1;
              ext_d          = 1'b0;
              brk_d          = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
      endcase
    end else if (state_q != S_IDLE && wd_q == TO) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      sh_q           <= '0;
      par_q          <= 1'b0;
      ext_q          <= 1'b0;
      brk_q          <= 1'b0;
      wd_q           <= '0;
      scan_code_q    <= '0;
      key_code_q     <= '0;
      key_extended_q <= 1'b0;
      key_released_q <= 1'b0;
      scan_valid_q   <= 1'b0;
      key_valid_q    <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sh_q           <= sh_d;
      par_q          <= par_d;
      ext_q          <= ext_d;
      brk_q          <= brk_d;
      wd_q           <= wd_d;
      scan_code_q    <= scan_code_d;
      key_code_q     <= key_code_d;
      key_extended_q <= key_extended_d;
      key_released_q <= key_released_d;
      scan_valid_q   <= scan_valid_d;
      key_valid_q    <= key_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end
  assign scan_code    = scan_code_q;
  assign scan_valid   = scan_valid_q;
  assign key_code     = key_code_q;
  assign key_extended = key_extended_q;
  assign key_released = key_released_q;
  assign key_valid    = key_valid_q;
  assign frame_err    = frame_err_q;
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: scoreboard bench for ps2_receiver with a fast PS/2 clock
module tb_ps2_receiver;
  import ps2_receiver_pkg::*;
  localparam int TO = 200;
  localparam int H = 20;
  logic CLOCK_50 = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic [7:0] scan_code, key_code;
  logic scan_valid, key_extended, key_released, key_valid, frame_err;
  int checks = 0, errors = 0;
  logic [7:0] scan_q[$];
  logic [9:0] key_q[$];
  bit err_q[$];
  ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .key_code    (key_code),
    .key_extended(key_extended),
    .key_released(key_released),
    .key_valid   (key_valid),
    .frame_err   (frame_err)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(negedge CLOCK_50) begin
    logic [7:0] es;
    logic [9:0] ek;
    if (scan_valid) begin
      checks++;
      if (scan_q.size() == 0) begin
        errors++;
        $display("FAIL scan_valid_unexpected: got scan_code %h, required no pulse", scan_code);
      end else begin
        es = scan_q.pop_front();
        if (scan_code !== es) begin
          errors++;
          $display("FAIL scan_code: got %h required %h", scan_code, es);
        end
      end
    end
    if (key_valid) begin
      checks++;
      if (key_q.size() == 0) begin
        errors++;
        $display("FAIL key_valid_unexpected: got %b%b_%h, required no pulse", key_extended, key_released, key_code);
      end else begin
        ek = key_q.pop_front();
        if ({key_extended, key_released, key_code} !== ek) begin
          errors++;
          $display("FAIL key_event: got ext=%b rel=%b code=%h required ext=%b rel=%b code=%h",
                   key_extended, key_released, key_code, ek[9], ek[8], ek[7:0]);
        end
      end
    end
    if (frame_err) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL frame_err_unexpected: got 1 required 0");
      end else void'(err_q.pop_front());
    end
  end
  task automatic send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (H) @(negedge CLOCK_50);
      ps2_clk = 1'b0;
      repeat (H) @(negedge CLOCK_50);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (3 * H) @(negedge CLOCK_50);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    checks++;
    if ({scan_code, scan_valid, key_code, key_extended, key_released, key_valid, frame_err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%h/%b/%b/%b/%b required all 0",
               scan_code, scan_valid, key_code, key_extended, key_released, key_valid, frame_err);
    end
    checks++;
    if (dut.state_q !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dut.state_q, S_IDLE);
    end
    reset = 1'b0;
    repeat (10) @(negedge CLOCK_50);
  endtask
  task automatic test_make;
    scan_q.push_back(8'h1C);
    key_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 1'b0, 11);
    checks++;
    if (scan_q.size() + key_q.size() !== 0) begin
      errors++;
      $display("FAIL make_drain: got %0d pending required 0", scan_q.size() + key_q.size());
    end
  endtask
  task automatic test_break;
    scan_q.push_back(8'hF0);
    scan_q.push_back(8'h1C);
    key_q.push_back({2'b01, 8'h1C});
    send(8'hF0, 1'b0, 11);
    send(8'h1C, 1'b0, 11);
    checks++;
    if (scan_q.size() + key_q.size() !== 0) begin
      errors++;
      $display("FAIL break_drain: got %0d pending required 0", scan_q.size() + key_q.size());
    end
  endtask
  task automatic test_ext_break;
    scan_q.push_back(8'hE0);
    scan_q.push_back(8'hF0);
    scan_q.push_back(8'h75);
    scan_q.push_back(8'h75);
    key_q.push_back({2'b11, 8'h75});
    key_q.push_back({2'b00, 8'h75});
    send(8'hE0, 1'b0, 11);
    send(8'hF0, 1'b0, 11);
    send(8'h75, 1'b0, 11);
    send(8'h75, 1'b0, 11);
    checks++;
    if (scan_q.size() + key_q.size() !== 0) begin
      errors++;
      $display("FAIL ext_break_drain: got %0d pending required 0", scan_q.size() + key_q.size());
    end
  endtask
  task automatic test_bad_parity;
    err_q.push_back(1'b1);
    send(8'h29, 1'b1, 11);
    checks++;
    if (err_q.size() !== 0) begin
      errors++;
      $display("FAIL parity_err_seen: got %0d pending required 0", err_q.size());
    end
    checks++;
    if (scan_code !== 8'h75) begin
      errors++;
      $display("FAIL parity_scan_hold: got %h required 75", scan_code);
    end
    scan_q.push_back(8'h29);
    key_q.push_back({2'b00, 8'h29});
    send(8'h29, 1'b0, 11);
    checks++;
    if (scan_q.size() + key_q.size() !== 0) begin
      errors++;
      $display("FAIL parity_recover: got %0d pending required 0", scan_q.size() + key_q.size());
    end
  endtask
  task automatic test_timeout;
    scan_q.push_back(8'hE0);
    send(8'hE0, 1'b0, 11);
    err_q.push_back(1'b1);
    send(8'h33, 1'b0, 5);
    repeat (TO + 5) @(negedge CLOCK_50);
    checks++;
    if (err_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_err: got %0d pending required 0", err_q.size());
    end
    checks++;
    if (dut.state_q !== S_IDLE) begin
      errors++;
      $display("FAIL timeout_idle: got %0d required %0d", dut.state_q, S_IDLE);
    end
    scan_q.push_back(8'h5A);
    key_q.push_back({2'b00, 8'h5A});
    send(8'h5A, 1'b0, 11);
    checks++;
    if (scan_code !== 8'h5A || scan_q.size() + key_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_recover: got %h with %0d pending required 5A with 0", scan_code, scan_q.size() + key_q.size());
    end
  endtask
  task automatic test_reset_mid;
    send(8'h1C, 1'b0, 7);
    reset = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    checks++;
    if ({scan_code, scan_valid, key_code, key_extended, key_released, key_valid, frame_err} !== 21'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h/%b/%h/%b/%b/%b/%b required all 0",
               scan_code, scan_valid, key_code, key_extended, key_released, key_valid, frame_err);
    end
    reset = 1'b0;
    repeat (TO + 20) @(negedge CLOCK_50);
    checks++;
    if (scan_code !== 8'h00 || dut.state_q !== S_IDLE) begin
      errors++;
      $display("FAIL midreset_quiet: got scan %h state %0d required 00 and %0d", scan_code, dut.state_q, S_IDLE);
    end
    scan_q.push_back(8'h1C);
    key_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 1'b0, 11);
    checks++;
    if (scan_q.size() + key_q.size() !== 0) begin
      errors++;
      $display("FAIL midreset_recover: got %0d pending required 0", scan_q.size() + key_q.size());
    end
  endtask
  initial begin
    test_reset;
    test_make;
    test_break;
    test_ext_break;
    test_bad_parity;
    test_timeout;
    test_reset_mid;
    checks++;
    if (scan_q.size() + key_q.size() + err_q.size() !== 0) begin
      errors++;
      $display("FAIL final_drain: got %0d pending required 0", scan_q.size() + key_q.size() + err_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
